// File: rtl/in_fifo_serializer_if.sv
// Bus bundle between the CPU write side / Tx bit-request side and the N->1 transmit FIFO.
// The FIFO takes the slave modport.
interface in_fifo_serializer_if #(
    parameter int unsigned DATA_SIZE_BIT = 3,
    parameter int unsigned FIFO_SIZE_BIT = 4
);
    logic                          inWriteEnable;
    logic [2**DATA_SIZE_BIT-1:0]   inData;
    logic                          inReadEnable;
    logic                          outData;
    logic                          outDone;
    logic [FIFO_SIZE_BIT:0]        outFilling;
    logic                          outFull;
    logic                          outEmpty;
    logic                          outAlmostFull;
    logic                          outAlmostEmpty;
    logic                          outWriteError;
    logic                          outReadError;

    modport slave (
        input  inWriteEnable, inData, inReadEnable,
        output outData, outDone, outFilling, outFull, outEmpty,
               outAlmostFull, outAlmostEmpty, outWriteError, outReadError
    );

    modport master (
        output inWriteEnable, inData, inReadEnable,
        input  outData, outDone, outFilling, outFull, outEmpty,
               outAlmostFull, outAlmostEmpty, outWriteError, outReadError
    );
endinterface

// File: rtl/in_fifo_serializer.sv
// Transmit FIFO: CPU writes whole words, the Tx modulator reads them back one bit per request,
// MSB first. Every access is an edge-triggered multi-cycle FSM operation.
module in_fifo_serializer #(
    parameter int unsigned DATA_SIZE_BIT = 3,
    parameter int unsigned FIFO_SIZE_BIT = 4
) (
    input logic                  inClock,
    input logic                  inReset,
    in_fifo_serializer_if.slave  bus_io
);
    localparam int unsigned DATA_WIDTH          = 2**DATA_SIZE_BIT;
    localparam int unsigned FIFO_DEPTH          = 2**FIFO_SIZE_BIT;
    localparam int unsigned ALMOST_EMPTY_OFFSET = FIFO_DEPTH / 4;
    localparam int unsigned ALMOST_FULL_OFFSET  = 3 * FIFO_DEPTH / 4;

    localparam logic [FIFO_SIZE_BIT:0] FillMax   = (FIFO_SIZE_BIT+1)'(FIFO_DEPTH);
    localparam logic [FIFO_SIZE_BIT:0] FillAEmpty = (FIFO_SIZE_BIT+1)'(ALMOST_EMPTY_OFFSET);
    localparam logic [FIFO_SIZE_BIT:0] FillAFull  = (FIFO_SIZE_BIT+1)'(ALMOST_FULL_OFFSET);
    localparam logic [DATA_SIZE_BIT-1:0] KMax     = DATA_SIZE_BIT'(DATA_WIDTH - 1);

    typedef enum logic [3:0] {
        StIdle,
        StWCheck,
        StRCheck,
        StWRCheck,
        StWrite,
        StRead,
        StReadWrite,
        StWError,
        StRError,
        StDone
    } state_e;

    state_e                    state_q;
    logic [FIFO_SIZE_BIT-1:0]  wr_ptr_q;
    logic [FIFO_SIZE_BIT-1:0]  rd_ptr_q;
    logic [DATA_SIZE_BIT-1:0]  k_q;
    logic [FIFO_SIZE_BIT:0]    filling_q;
    logic                      data_q;
    logic                      done_q;
    logic                      wr_err_q;
    logic                      rd_err_q;
    logic                      prev_w_q;
    logic                      prev_r_q;
    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];

    logic start_w;
    logic start_r;
    logic full;
    logic empty;
    logic word_done;
    logic head_bit;

    assign start_w   = bus_io.inWriteEnable & ~prev_w_q;
    assign start_r   = bus_io.inReadEnable & ~prev_r_q;
    assign full      = (filling_q == FillMax);
    assign empty     = (filling_q == '0);
    assign word_done = (k_q == KMax);
    assign head_bit  = mem_q[rd_ptr_q][KMax - k_q];

    always_ff @(posedge inClock) begin
        if (inReset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            k_q       <= '0;
            filling_q <= '0;
            data_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            prev_w_q  <= 1'b0;
            prev_r_q  <= 1'b0;
        end else begin
            prev_w_q <= bus_io.inWriteEnable;
            prev_r_q <= bus_io.inReadEnable;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_r && start_w)  state_q <= StWRCheck;
                    else if (start_r)        state_q <= StRCheck;
                    else if (start_w)        state_q <= StWCheck;
                end
                StWCheck: state_q <= full ? StWError : StWrite;
                StRCheck: state_q <= empty ? StRError : StRead;
                StWRCheck: begin
                    if (empty) begin
                        rd_err_q <= 1'b1;
                        state_q  <= StWrite;
                    end else begin
                        state_q  <= StReadWrite;
                    end
                end
                StWrite: begin
                    mem_q[wr_ptr_q] <= bus_io.inData;
                    wr_ptr_q  <= wr_ptr_q + 1'b1;
                    filling_q <= filling_q + 1'b1;
                    wr_err_q  <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= StDone;
                end
                StRead: begin
                    data_q   <= head_bit;
                    rd_err_q <= 1'b0;
                    if (word_done) begin
                        k_q       <= '0;
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        filling_q <= filling_q - 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StReadWrite: begin
                    // Count is unchanged since the check state, so full here equals full at check.
                    data_q   <= head_bit;
                    rd_err_q <= 1'b0;
                    wr_err_q <= full;
                    if (!full) begin
                        mem_q[wr_ptr_q] <= bus_io.inData;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (word_done) begin
                        k_q      <= '0;
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                    if (!full && !word_done)      filling_q <= filling_q + 1'b1;
                    else if (full && word_done)   filling_q <= filling_q - 1'b1;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StWError: begin
                    wr_err_q <= 1'b1;
                    state_q  <= StIdle;
                end
                StRError: begin
                    rd_err_q <= 1'b1;
                    state_q  <= StIdle;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.outData        = data_q;
    assign bus_io.outDone        = done_q;
    assign bus_io.outFilling     = filling_q;
    assign bus_io.outFull        = full;
    assign bus_io.outEmpty       = empty;
    assign bus_io.outAlmostFull  = (filling_q >= FillAFull);
    assign bus_io.outAlmostEmpty = (filling_q <= FillAEmpty);
    assign bus_io.outWriteError  = wr_err_q;
    assign bus_io.outReadError   = rd_err_q;
endmodule

// File: tb/tb_in_fifo_serializer.sv
// Directed bench for the transmit FIFO: serialization order, error flags, thresholds,
// combined read/write, held enables and mid-operation reset.
module tb_in_fifo_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #10 clk = ~clk;

    in_fifo_serializer_if #(.DATA_SIZE_BIT(3), .FIFO_SIZE_BIT(4)) bus ();

    in_fifo_serializer #(.DATA_SIZE_BIT(3), .FIFO_SIZE_BIT(4)) dut (
        .inClock (clk),
        .inReset (rst),
        .bus_io  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse the enables for one cycle, then sample three cycles after the edge was taken.
    task automatic op(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        @(negedge clk);
        bus.inWriteEnable = w;
        bus.inReadEnable  = r;
        bus.inData        = d;
        @(posedge clk);
        @(negedge clk);
        bus.inWriteEnable = 1'b0;
        bus.inReadEnable  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic rd_word(input logic [7:0] w, input string tag);
        for (int b = 0; b < 8; b++) begin
            op(1'b0, 1'b1, 8'h00);
            chk({tag, "_bit"}, {31'd0, bus.outData}, {31'd0, w[7-b]});
            chk({tag, "_done"}, {31'd0, bus.outDone}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] a5;
        int         cnt;
        bus.inWriteEnable = 1'b0;
        bus.inReadEnable  = 1'b0;
        bus.inData        = 8'h00;
        a5 = 8'hA5;

        // 1: reset state, then serialize 0xA5
        do_reset();
        #1;
        chk("rst_filling", 32'(bus.outFilling), 32'd0);
        chk("rst_empty", {31'd0, bus.outEmpty}, 32'd1);
        chk("rst_aempty", {31'd0, bus.outAlmostEmpty}, 32'd1);
        chk("rst_full", {31'd0, bus.outFull}, 32'd0);
        chk("rst_afull", {31'd0, bus.outAlmostFull}, 32'd0);
        chk("rst_done", {31'd0, bus.outDone}, 32'd0);
        chk("rst_data", {31'd0, bus.outData}, 32'd0);
        chk("rst_werr", {31'd0, bus.outWriteError}, 32'd0);
        chk("rst_rerr", {31'd0, bus.outReadError}, 32'd0);
        op(1'b1, 1'b0, 8'hA5);
        chk("t1_wdone", {31'd0, bus.outDone}, 32'd1);
        chk("t1_wfill", 32'(bus.outFilling), 32'd1);
        for (int b = 0; b < 8; b++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("t1_bit", {31'd0, bus.outData}, {31'd0, a5[7-b]});
            chk("t1_done", {31'd0, bus.outDone}, 32'd1);
            chk("t1_fill", 32'(bus.outFilling), (b == 7) ? 32'd0 : 32'd1);
        end
        chk("t1_empty", {31'd0, bus.outEmpty}, 32'd1);

        // 2: read while empty, then recover
        op(1'b0, 1'b1, 8'h00);
        chk("t2_rerr", {31'd0, bus.outReadError}, 32'd1);
        chk("t2_nodone", {31'd0, bus.outDone}, 32'd0);
        chk("t2_hold", {31'd0, bus.outData}, 32'd1);
        op(1'b1, 1'b0, 8'h80);
        chk("t2_rerr_wr", {31'd0, bus.outReadError}, 32'd1);
        op(1'b0, 1'b1, 8'h00);
        chk("t2_bit", {31'd0, bus.outData}, 32'd1);
        chk("t2_rerr_clr", {31'd0, bus.outReadError}, 32'd0);
        chk("t2_fill", 32'(bus.outFilling), 32'd1);

        // 3: fill, thresholds, overflow, drain, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, 8'(i));
            chk("t3_fill", 32'(bus.outFilling), 32'(i + 1));
            chk("t3_afull", {31'd0, bus.outAlmostFull}, {31'd0, (i + 1) >= 12});
            chk("t3_aempty", {31'd0, bus.outAlmostEmpty}, {31'd0, (i + 1) <= 4});
            chk("t3_full", {31'd0, bus.outFull}, {31'd0, (i + 1) == 16});
        end
        op(1'b1, 1'b0, 8'hEE);
        chk("t3_ovf_werr", {31'd0, bus.outWriteError}, 32'd1);
        chk("t3_ovf_fill", 32'(bus.outFilling), 32'd16);
        chk("t3_ovf_done", {31'd0, bus.outDone}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_word(8'(i), "t3_drain");
            chk("t3_dfill", 32'(bus.outFilling), 32'(15 - i));
        end
        chk("t3_empty", {31'd0, bus.outEmpty}, 32'd1);
        op(1'b1, 1'b0, 8'hC3);
        chk("t3_werr_clr", {31'd0, bus.outWriteError}, 32'd0);
        op(1'b1, 1'b0, 8'h3C);
        op(1'b1, 1'b0, 8'h5A);
        op(1'b1, 1'b0, 8'hF0);
        chk("t3_wrap_fill", 32'(bus.outFilling), 32'd4);
        rd_word(8'hC3, "t3_w0");
        rd_word(8'h3C, "t3_w1");
        rd_word(8'h5A, "t3_w2");
        rd_word(8'hF0, "t3_w3");
        chk("t3_wrap_empty", {31'd0, bus.outEmpty}, 32'd1);

        // 4: full with 7 head bits consumed, simultaneous read+write
        do_reset();
        op(1'b1, 1'b0, 8'h01);
        for (int i = 1; i < 16; i++) op(1'b1, 1'b0, 8'(i));
        for (int b = 0; b < 7; b++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("t4_pre", {31'd0, bus.outData}, 32'd0);
        end
        op(1'b1, 1'b1, 8'h77);
        chk("t4_done", {31'd0, bus.outDone}, 32'd1);
        chk("t4_bit0", {31'd0, bus.outData}, 32'd1);
        chk("t4_fill", 32'(bus.outFilling), 32'd15);
        chk("t4_werr", {31'd0, bus.outWriteError}, 32'd1);
        for (int i = 1; i < 16; i++) rd_word(8'(i), "t4_drain");
        chk("t4_empty", {31'd0, bus.outEmpty}, 32'd1);

        // 4b: simultaneous read+write with room: write lands, word not finished
        do_reset();
        op(1'b1, 1'b0, 8'h96);
        op(1'b1, 1'b1, 8'h3C);
        chk("t4b_bit", {31'd0, bus.outData}, 32'd1);
        chk("t4b_fill", 32'(bus.outFilling), 32'd2);
        chk("t4b_werr", {31'd0, bus.outWriteError}, 32'd0);
        for (int b = 1; b < 8; b++) begin
            op(1'b0, 1'b1, 8'h00);
            chk("t4b_rest", {31'd0, bus.outData}, {31'd0, a5[0] & (b == 3 || b == 5 || b == 6)});
        end
        rd_word(8'h3C, "t4b_w1");

        // 5: enable held high is a single write
        do_reset();
        cnt = 0;
        @(negedge clk);
        bus.inWriteEnable = 1'b1;
        bus.inData        = 8'h5A;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.outDone) cnt++;
        end
        bus.inWriteEnable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.outDone) cnt++;
        end
        chk("t5_pulses", 32'(cnt), 32'd1);
        chk("t5_fill", 32'(bus.outFilling), 32'd1);

        // 6: reset while the write op is in progress
        do_reset();
        @(negedge clk);
        bus.inWriteEnable = 1'b1;
        bus.inData        = 8'hAB;
        @(posedge clk);
        @(negedge clk);
        bus.inWriteEnable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_fill", 32'(bus.outFilling), 32'd0);
        chk("t6_empty", {31'd0, bus.outEmpty}, 32'd1);
        chk("t6_done", {31'd0, bus.outDone}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op(1'b0, 1'b1, 8'h00);
        chk("t6_rerr", {31'd0, bus.outReadError}, 32'd1);
        chk("t6_nodone", {31'd0, bus.outDone}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
